cv32e40p_apu_arbiter: RTL and testbench

//  Shares one FP wrapper (APU slave) among NUM_CORES CV32E40P APU master ports.
//  - Round-robin arbitration of requests.
//  - Keeps an in-order FIFO of granted requester IDs.
//  - Routes each result (rvalid/rdata/rflags) back to the requester that issued it.
//  - Sits in the cluster top, between the core_i APU ports and a single fp_wrapper_i.

---
 rtl/cv32e40p_apu_core_pkg.sv | 20 ++
 rtl/cv32e40p_apu_id_fifo.sv | 68 ++++++
 rtl/cv32e40p_apu_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU core package: CV32E40P APU interface widths plus the request payload
// type and limits used by the shared-FPU arbiter.
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;

    // Upper bound on the number of cores sharing one FP wrapper
    localparam int APU_ARB_MAX_CORES = 8;

    // Everything a core presents alongside apu_req
    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0] operands;
        logic [APU_WOP_CPU-1:0]         op;
        logic [APU_NDSFLAGS_CPU-1:0]    flags;
    } apu_req_payload_t;

endpackage

// File: rtl/cv32e40p_apu_id_fifo.sv
// In-order FIFO of requester IDs granted to the shared FP wrapper.
// Push is ignored when full and pop is ignored when empty; simultaneous
// push/pop advances both pointers and leaves the count unchanged.
module cv32e40p_apu_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]              cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for storage, pointers (wrap naturally) and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset discards all queued IDs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Shares one FP wrapper among NUM_CORES CV32E40P APU master ports.
// Round-robin winner selection with a lock that holds the winner while the
// wrapper stalls, an in-order ID FIFO for routing results back, and a sticky
// error flag for results that arrive with nothing outstanding.
// Optional: define CV32E40P_APU_ARB_PERF_EN to add per-core grant and stall
// counters (perf_grant_cnt_o / perf_stall_cnt_o).
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic [NUM_CORES-1:0]                           core_req_i,
    output logic [NUM_CORES-1:0]                           core_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]  core_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]          core_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]     core_flags_i,
    output logic [NUM_CORES-1:0]                           core_rvalid_o,
    output logic [31:0]                                    core_rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                    core_rflags_o,
    output logic                                           fpu_req_o,
    input  logic                                           fpu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                 fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]                         fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                    fpu_flags_o,
    input  logic                                           fpu_rvalid_i,
    input  logic [31:0]                                    fpu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                    fpu_rflags_i,
    output logic                                           arb_err_o
`ifdef CV32E40P_APU_ARB_PERF_EN
    ,
    output logic [NUM_CORES-1:0][31:0]                     perf_grant_cnt_o,
    output logic [NUM_CORES-1:0][31:0]                     perf_stall_cnt_o
`endif
);

    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    typedef logic [ID_W-1:0] id_t;

    // Index of the core at offset 'off' from 'ptr', wrapping at NUM_CORES
    function automatic id_t rr_idx(input int ptr, input int off);
        int s;
        s = ptr + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return id_t'(s);
    endfunction

    apu_req_payload_t [NUM_CORES-1:0] payload;
    apu_req_payload_t                 sel_payload;

    id_t  rr_ptr_q, rr_ptr_d;
    id_t  locked_id_q, locked_id_d;
    logic locked_q, locked_d;
    logic err_q, err_d;
    id_t  rr_winner, winner;
    logic handshake;
    logic fifo_full, fifo_empty, fifo_pop;
    id_t  fifo_head;

    // Pack each core's request fields into one payload word
    always_comb begin
        payload = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            payload[c].operands = core_operands_i[c];
            payload[c].op       = core_op_i[c];
            payload[c].flags    = core_flags_i[c];
        end
    end

    // First requester at or after rr_ptr; lowest offset wins (scan from far end)
    always_comb begin
        rr_winner = rr_ptr_q;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (core_req_i[rr_idx(int'(rr_ptr_q), i)]) rr_winner = rr_idx(int'(rr_ptr_q), i);
        end
    end

    // A stalled request keeps its core selected until the wrapper accepts it
    assign winner = locked_q ? locked_id_q : rr_winner;

    // Request path is purely combinational; reset forces the request low so
    // nothing can handshake while state is being cleared
    assign fpu_req_o   = rst_ni & (|core_req_i) & ~fifo_full;
    assign handshake   = fpu_req_o & fpu_gnt_i;
    assign sel_payload = payload[winner];

    assign fpu_operands_o = sel_payload.operands;
    assign fpu_op_o       = sel_payload.op;
    assign fpu_flags_o    = sel_payload.flags;

    // Grant back to the winning core on the handshake cycle only
    always_comb begin
        core_gnt_o = '0;
        if (handshake) core_gnt_o[winner] = 1'b1;
    end

    // Results are routed to the oldest outstanding requester; data is broadcast
    assign fifo_pop = fpu_rvalid_i & ~fifo_empty;

    always_comb begin
        core_rvalid_o = '0;
        if (fifo_pop) core_rvalid_o[fifo_head] = 1'b1;
    end

    assign core_rdata_o  = fpu_rdata_i;
    assign core_rflags_o = fpu_rflags_i;
    assign arb_err_o     = err_q;

    // Next-state for round-robin pointer, lock and sticky error
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        locked_d    = locked_q;
        locked_id_d = locked_id_q;
        err_d       = err_q | (fpu_rvalid_i & fifo_empty);
        if (handshake) begin
            rr_ptr_d = (winner == id_t'(NUM_CORES - 1)) ? '0 : winner + id_t'(1);
            locked_d = 1'b0;
        end else if (fpu_req_o) begin
            locked_d    = 1'b1;
            locked_id_d = winner;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            locked_q    <= 1'b0;
            locked_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            locked_q    <= locked_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
        end
    end

    cv32e40p_apu_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) id_fifo_i (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (handshake),
        .push_id_i (winner),
        .pop_i     (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [NUM_CORES-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [NUM_CORES-1:0][31:0] stall_cnt_q, stall_cnt_d;

    // Per-core handshake and stall-cycle counters, wrapping at 2^32
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (core_gnt_o[c])                  grant_cnt_d[c] = grant_cnt_q[c] + 32'd1;
            if (core_req_i[c] & ~core_gnt_o[c]) stall_cnt_d[c] = stall_cnt_q[c] + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant_cnt_o = grant_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Scoreboard bench for cv32e40p_apu_arbiter: stimulus pushes expected grants
// and results into queues, a negedge monitor pops and compares them.
module tb_cv32e40p_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]                         core_req, core_gnt, core_rvalid;
    logic [3:0][APU_NARGS_CPU-1:0][31:0] core_operands;
    logic [3:0][APU_WOP_CPU-1:0]        core_op;
    logic [3:0][APU_NDSFLAGS_CPU-1:0]   core_flags;
    logic [31:0]                        core_rdata, fpu_rdata;
    logic [APU_NUSFLAGS_CPU-1:0]        core_rflags, fpu_rflags;
    logic                               fpu_req, fpu_gnt, fpu_rvalid, arb_err;
    logic [APU_NARGS_CPU-1:0][31:0]     fpu_operands;
    logic [APU_WOP_CPU-1:0]             fpu_op;
    logic [APU_NDSFLAGS_CPU-1:0]        fpu_flags;
`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [3:0][31:0]                   perf_grant_cnt, perf_stall_cnt;
`endif

    cv32e40p_apu_arbiter #(.NUM_CORES(4), .MAX_OUTSTANDING(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .core_req_i      (core_req),
        .core_gnt_o      (core_gnt),
        .core_operands_i (core_operands),
        .core_op_i       (core_op),
        .core_flags_i    (core_flags),
        .core_rvalid_o   (core_rvalid),
        .core_rdata_o    (core_rdata),
        .core_rflags_o   (core_rflags),
        .fpu_req_o       (fpu_req),
        .fpu_gnt_i       (fpu_gnt),
        .fpu_operands_o  (fpu_operands),
        .fpu_op_o        (fpu_op),
        .fpu_flags_o     (fpu_flags),
        .fpu_rvalid_i    (fpu_rvalid),
        .fpu_rdata_i     (fpu_rdata),
        .fpu_rflags_i    (fpu_rflags),
        .arb_err_o       (arb_err)
`ifdef CV32E40P_APU_ARB_PERF_EN
        ,
        .perf_grant_cnt_o(perf_grant_cnt),
        .perf_stall_cnt_o(perf_stall_cnt)
`endif
    );

    // Fixed per-core payload table
    function automatic logic [APU_WOP_CPU-1:0] exp_op(input int c);
        return APU_WOP_CPU'(c + 5);
    endfunction
    function automatic logic [31:0] exp_opnd0(input int c);
        return 32'hA000_0000 + 32'(c);
    endfunction

    typedef struct { int core; logic [31:0] data; } res_t;
    int   exp_gnt[$];
    res_t exp_res[$];

    int checks = 0;
    int errors = 0;

    // Per-cycle direct expectations, set by stimulus, consumed by the monitor
    logic chk_zero = 1'b0, chk_req = 1'b0, chk_err = 1'b0, chk_op = 1'b0, chk_empty = 1'b0;
    logic e_req = 1'b0, e_err = 1'b0;
    int   e_op = 0;

    // Monitor: all comparisons happen here, on the falling edge
    always @(negedge clk) begin : mon
        int   g;
        res_t r;
        logic [3:0] want;
        if (chk_zero) begin
            checks++;
            if ({core_gnt, core_rvalid, fpu_req, arb_err} !== 10'b0) begin
                errors++;
                $display("FAIL reset_zero: gnt=%b rvalid=%b req=%b err=%b, want all 0",
                         core_gnt, core_rvalid, fpu_req, arb_err);
            end
        end
        if (chk_req) begin
            checks++;
            if (fpu_req !== e_req) begin
                errors++;
                $display("FAIL fpu_req: got %b want %b", fpu_req, e_req);
            end
        end
        if (chk_err) begin
            checks++;
            if (arb_err !== e_err) begin
                errors++;
                $display("FAIL arb_err: got %b want %b", arb_err, e_err);
            end
        end
        if (chk_op) begin
            checks++;
            if (fpu_op !== exp_op(e_op) || fpu_operands[0] !== exp_opnd0(e_op)) begin
                errors++;
                $display("FAIL mux_sel: op=%h opnd0=%h want core %0d (op=%h opnd0=%h)",
                         fpu_op, fpu_operands[0], e_op, exp_op(e_op), exp_opnd0(e_op));
            end
        end
        if (chk_empty) begin
            checks++;
            if (exp_gnt.size() != 0 || exp_res.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d grants and %0d results still expected, want 0 and 0",
                         exp_gnt.size(), exp_res.size());
            end
        end
        if (rst_n === 1'b1) begin
            if (core_gnt !== 4'b0) begin
                checks++;
                if (exp_gnt.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected core_gnt=%b, want none", core_gnt);
                end else begin
                    g = exp_gnt.pop_front();
                    want = 4'b0001 << g;
                    if (core_gnt !== want || fpu_op !== exp_op(g)) begin
                        errors++;
                        $display("FAIL grant: core_gnt=%b op=%h want %b op=%h",
                                 core_gnt, fpu_op, want, exp_op(g));
                    end
                end
            end
            if (fpu_rvalid === 1'b1) begin
                checks++;
                if (exp_res.size() == 0) begin
                    errors++;
                    $display("FAIL result: rvalid with no expectation, core_rvalid=%b", core_rvalid);
                end else begin
                    r = exp_res.pop_front();
                    want = (r.core < 0) ? 4'b0 : (4'b0001 << r.core);
                    if (core_rvalid !== want || core_rdata !== r.data || core_rflags !== r.data[4:0]) begin
                        errors++;
                        $display("FAIL result: core_rvalid=%b rdata=%h rflags=%h want %b %h %h",
                                 core_rvalid, core_rdata, core_rflags, want, r.data, r.data[4:0]);
                    end
                end
            end else if (core_rvalid !== 4'b0) begin
                checks++;
                errors++;
                $display("FAIL result: spurious core_rvalid=%b, want 0000", core_rvalid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk_zero = 1'b0; chk_req = 1'b0; chk_err = 1'b0; chk_op = 1'b0; chk_empty = 1'b0;
    endtask

    task automatic drive_res(input int core, input logic [31:0] d);
        res_t r;
        r.core = core;
        r.data = d;
        fpu_rvalid = 1'b1;
        fpu_rdata  = d;
        fpu_rflags = d[4:0];
        exp_res.push_back(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b0;
        chk_zero = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            for (int a = 0; a < APU_NARGS_CPU; a++)
                core_operands[c][a] = exp_opnd0(c) + 32'(a << 8);
            core_op[c]    = exp_op(c);
            core_flags[c] = APU_NDSFLAGS_CPU'(c * 3 + 1);
        end
        fpu_rdata = '0; fpu_rflags = '0;
        rst_n = 1'b0; core_req = '0; fpu_gnt = 1'b0; fpu_rvalid = 1'b0;
        chk_zero = 1'b1;
        tick();
        do_reset();

        // 1: single request from core2, result three cycles after the grant
        core_req = 4'b0100; fpu_gnt = 1'b1; exp_gnt.push_back(2);
        chk_op = 1'b1; e_op = 2;
        tick();
        core_req = '0; fpu_gnt = 1'b0;
        tick();
        tick();
        drive_res(2, 32'h3F80_0000);
        tick();
        fpu_rvalid = 1'b0;
        tick();

        // 2: all cores requesting, grants rotate 0,1,2,3,0; results follow
        do_reset();
        for (int k = 0; k < 5; k++) begin
            core_req = 4'hF; fpu_gnt = 1'b1;
            exp_gnt.push_back(k % 4);
            if (k > 0) drive_res(k - 1, 32'h0000_1000 + 32'(k));
            else fpu_rvalid = 1'b0;
            tick();
        end
        core_req = '0; fpu_gnt = 1'b0;
        drive_res(0, 32'h0000_2000);
        tick();
        fpu_rvalid = 1'b0;
        tick();

        // 3: core1 stalled by the wrapper stays locked while core0 requests
        do_reset();
        core_req = 4'b0010; fpu_gnt = 1'b0;
        chk_req = 1'b1; e_req = 1'b1; chk_op = 1'b1; e_op = 1;
        tick();
        for (int k = 0; k < 2; k++) begin
            core_req = 4'b0011; fpu_gnt = 1'b0; chk_op = 1'b1; e_op = 1;
            tick();
        end
        core_req = 4'b0011; fpu_gnt = 1'b1; exp_gnt.push_back(1);
        tick();
        core_req = 4'b0001; fpu_gnt = 1'b1; exp_gnt.push_back(0);
        tick();
        core_req = '0; fpu_gnt = 1'b0;
        drive_res(1, 32'h4000_0000);
        tick();
        drive_res(0, 32'h4040_0000);
        tick();
        fpu_rvalid = 1'b0;

        // 4: FIFO full blocks grants, even on a pop cycle; resumes after
        do_reset();
        for (int k = 0; k < 4; k++) begin
            core_req = 4'b0001 << k; fpu_gnt = 1'b1; exp_gnt.push_back(k);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            core_req = 4'b1000; fpu_gnt = 1'b1; chk_req = 1'b1; e_req = 1'b0;
            tick();
        end
        drive_res(0, 32'h0000_5000); chk_req = 1'b1; e_req = 1'b0;
        tick();
        fpu_rvalid = 1'b0; exp_gnt.push_back(3); chk_req = 1'b1; e_req = 1'b1;
        tick();
        core_req = '0; fpu_gnt = 1'b0;
        drive_res(1, 32'h0000_5001); tick();
        drive_res(2, 32'h0000_5002); tick();
        drive_res(3, 32'h0000_5003); tick();
        drive_res(3, 32'h0000_5004); tick();
        fpu_rvalid = 1'b0;

        // 5: result with nothing outstanding is dropped and flags a sticky error
        do_reset();
        drive_res(-1, 32'h0000_6000);
        tick();
        fpu_rvalid = 1'b0; chk_err = 1'b1; e_err = 1'b1;
        tick();
        chk_err = 1'b1; e_err = 1'b1;
        tick();
        do_reset();
        chk_err = 1'b1; e_err = 1'b0;
        tick();

        // 6: reset with two outstanding clears everything at once
        core_req = 4'b0011; fpu_gnt = 1'b1; exp_gnt.push_back(0);
        tick();
        core_req = 4'b0010; fpu_gnt = 1'b1; exp_gnt.push_back(1);
        tick();
        rst_n = 1'b0; core_req = 4'b0011; fpu_gnt = 1'b1; fpu_rvalid = 1'b1;
        chk_zero = 1'b1;
        tick();
        rst_n = 1'b1; fpu_rvalid = 1'b0;
        core_req = 4'b0011; fpu_gnt = 1'b1; exp_gnt.push_back(0);
        tick();
        core_req = '0; fpu_gnt = 1'b0;
        drive_res(0, 32'h0000_7000);
        tick();
        fpu_rvalid = 1'b0; chk_empty = 1'b1; chk_err = 1'b1; e_err = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
